// File: rtl/pll_clock_synth_if.sv
`default_nettype none
// ============================================================================
//  Module   : pll_clock_synth_if
//  Brief    : Frequency-control and status bundle of the NCO clock synthesizer.
//  Revision : 1.0 - initial release
// ============================================================================
interface pll_clock_synth_if #(
  parameter int ACC_WIDTH = 32
);
  logic [ACC_WIDTH-1:0] freq_word;
  logic                 freq_load;
  logic                 clock_out;
  logic                 locked;

  modport master (
    output freq_word,
    output freq_load,
    input  clock_out,
    input  locked
  );

  modport slave (
    input  freq_word,
    input  freq_load,
    output clock_out,
    output locked
  );
endinterface
`default_nettype wire

// File: rtl/pll_clock_synth.sv
`default_nettype none
// ============================================================================
//  Module   : pll_clock_synth
//  Brief    : Phase-accumulator clock synthesizer with lock indicator.
//             Define PLL_RELOCK_EN to drop lock whenever the increment changes.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_clock_synth #(
  parameter int                   ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] FREQ_WORD   = ACC_WIDTH'(64'd1 << (ACC_WIDTH - 2)),
  parameter int                   LOCK_CYCLES = 1024
) (
  input  wire logic        clock_in,
  input  wire logic        reset,
  pll_clock_synth_if.slave bus
);

  localparam int                   c_cnt_w   = $clog2(LOCK_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(LOCK_CYCLES - 1);
  localparam logic [ACC_WIDTH-1:0] c_half    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_inc;
  logic [c_cnt_w-1:0]   r_lock_cnt;
  logic                 r_locked;

  logic [ACC_WIDTH-1:0] w_load_val;
  logic                 w_accept;
  logic                 w_relock;

  // Zero words are dropped; anything above half scale would alias, so clamp to f_in/2.
  always_comb begin
    w_load_val = (bus.freq_word > c_half) ? c_half : bus.freq_word;
    w_accept   = bus.freq_load && (bus.freq_word != '0);
`ifdef PLL_RELOCK_EN
    w_relock   = w_accept && (w_load_val != r_inc);
`else
    w_relock   = 1'b0;
`endif
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_acc      <= '0;
      r_inc      <= FREQ_WORD;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_acc <= r_acc + r_inc;
      if (w_accept) begin
        r_inc <= w_load_val;
      end
      if (w_relock) begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else if (!r_locked) begin
        if (r_lock_cnt == c_cnt_max) begin
          r_locked <= 1'b1;
        end else begin
          r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
        end
      end
    end
  end

  assign bus.clock_out = r_acc[ACC_WIDTH-1];
  assign bus.locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pll_clock_synth.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_clock_synth
//  Brief    : Self-checking bench for pll_clock_synth against a phase model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_clock_synth;

  localparam int W  = 8;
  localparam int FW = 64;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_clock_synth_if #(.ACC_WIDTH(W))  bus8 ();
  pll_clock_synth_if #(.ACC_WIDTH(32)) bus32 ();

  pll_clock_synth #(
    .ACC_WIDTH   (W),
    .FREQ_WORD   (8'd64),
    .LOCK_CYCLES (LC)
  ) dut8 (
    .clock_in (clk),
    .reset    (rst),
    .bus      (bus8.slave)
  );

  pll_clock_synth #(
    .ACC_WIDTH (32)
  ) dut32 (
    .clock_in (clk),
    .reset    (rst32),
    .bus      (bus32.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase as an integer fraction of one output period,
  // lock as "edges elapsed since the lock window opened".
  int m_phase = 0;
  int m_inc   = FW;
  int m_since = 0;
  bit m_valid = 1'b0;

  function automatic int clampw(input int w);
    return (w > 128) ? 128 : w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_inc   <= FW;
      m_since <= 0;
      m_valid <= 1'b1;
    end else begin
      m_phase <= (m_phase + m_inc) % 256;
      m_since <= (m_since < 100000) ? m_since + 1 : m_since;
      if (bus8.freq_load && bus8.freq_word != 0) begin
        m_inc <= clampw(int'(bus8.freq_word));
`ifdef PLL_RELOCK_EN
        if (clampw(int'(bus8.freq_word)) != m_inc) m_since <= 0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("clock_out", 32'(bus8.clock_out), 32'(m_phase >= 128));
      chk("locked",    32'(bus8.locked),    32'(m_since >= LC));
    end
  end

  task automatic count_rises(input bit sel32, input int n, output int r);
    logic prev;
    logic cur;
    r    = 0;
    prev = sel32 ? bus32.clock_out : bus8.clock_out;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur = sel32 ? bus32.clock_out : bus8.clock_out;
      if (!prev && cur) r++;
      prev = cur;
    end
  endtask

  task automatic load8(input logic [7:0] w);
    bus8.freq_word = w;
    bus8.freq_load = 1'b1;
    @(negedge clk);
    bus8.freq_load = 1'b0;
  endtask

  int  rises;
  int  pick;

  initial begin
    rst             = 1'b1;
    rst32           = 1'b1;
    bus8.freq_word  = '0;
    bus8.freq_load  = 1'b0;
    bus32.freq_word = '0;
    bus32.freq_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_clock_out", 32'(bus8.clock_out), 32'd0);
    chk("reset_locked",    32'(bus8.locked),    32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("edge1_clock_out", 32'(bus8.clock_out), 32'd0);
    @(negedge clk);
    chk("edge2_clock_out", 32'(bus8.clock_out), 32'd1);
    repeat (13) @(negedge clk);
    chk("locked_edge15", 32'(bus8.locked), 32'd0);
    @(negedge clk);
    chk("locked_edge16", 32'(bus8.locked), 32'd1);

    count_rises(1'b0, 16, rises);
    chk("period4_rises", 32'(rises), 32'd4);

    load8(8'd0);
    chk("zero_load_locked", 32'(bus8.locked), 32'd1);
    count_rises(1'b0, 16, rises);
    chk("zero_load_rises", 32'(rises), 32'd4);

    load8(8'd128);
    count_rises(1'b0, 8, rises);
    chk("half_rate_rises", 32'(rises), 32'd4);
    load8(8'd200);
    count_rises(1'b0, 8, rises);
    chk("clamped_rises", 32'(rises), 32'd4);

    repeat (20) @(negedge clk);
    load8(8'd64);
    repeat (20) @(negedge clk);
    chk("relocked_before_32", 32'(bus8.locked), 32'd1);
    load8(8'd32);
`ifdef PLL_RELOCK_EN
    chk("load32_locked", 32'(bus8.locked), 32'd0);
`else
    chk("load32_locked", 32'(bus8.locked), 32'd1);
`endif
    count_rises(1'b0, 32, rises);
    chk("period8_rises", 32'(rises), 32'd4);
    load8(8'd32);
    chk("reload32_locked", 32'(bus8.locked), 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_clock_out", 32'(bus8.clock_out), 32'd0);
    chk("midreset_locked",    32'(bus8.locked),    32'd0);
    repeat (2) @(negedge clk);
    chk("midreset_inc_restored", 32'(bus8.clock_out), 32'd1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus8.freq_load = ($urandom_range(0, 3) == 0);
      pick           = int'($urandom_range(0, 7));
      case (pick)
        0:       bus8.freq_word = 8'd0;
        1:       bus8.freq_word = 8'd128;
        2:       bus8.freq_word = 8'(m_inc);
        3:       bus8.freq_word = 8'd255;
        default: bus8.freq_word = 8'($urandom_range(0, 255));
      endcase
      @(negedge clk);
    end
    rst            = 1'b0;
    bus8.freq_load = 1'b0;

    rst32 = 1'b0;
    bus32.freq_word = 32'h1999999A;
    bus32.freq_load = 1'b1;
    @(negedge clk);
    bus32.freq_load = 1'b0;
    count_rises(1'b1, 1000, rises);
    checks++;
    if (rises < 99 || rises > 101) begin
      errors++;
      $display("FAIL div10_rises actual=%0d required=99..101", rises);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
